// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V main control unit:
// opcodes, FSM state codes, ALU operand select encodings and the control bundle.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADDR   = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXEC      = 4'd6,
        S_RCOMPLETE = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational next-state and output decode for the multicycle control FSM.
// Outputs are Moore except the FETCH write strobes and the DECODE illegal flag.
module multicycle_control_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_mem_ready,
    input  logic [6:0] i_opcode,
    output state_t     o_next,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        o_next = S_FETCH;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                // Gate the PC/IR load on mem_ready so a stalled fetch advances PC once.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
                o_next           = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                o_ctrl.alu_src_a = SRCA_OLDPC;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
                case (i_opcode)
                    OP_LD, OP_SD: o_next = S_MEMADDR;
                    OP_RTYPE:     o_next = S_EXEC;
                    OP_BEQ:       o_next = S_BRANCH;
                    default: begin
                        o_next         = S_FETCH;
                        o_ctrl.illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                o_ctrl.alu_src_a = SRCA_REG;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
                if (i_opcode == OP_LD)
                    o_next = S_MEMREAD;
                else if (i_opcode == OP_SD)
                    o_next = S_MEMWRITE;
                else
                    o_next = S_FETCH;
            end
            S_MEMREAD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
                o_next          = i_mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_next            = S_FETCH;
            end
            S_MEMWRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
                o_next           = i_mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = SRCA_REG;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
                o_next           = S_RCOMPLETE;
            end
            S_RCOMPLETE: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b0;
                o_next            = S_FETCH;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = SRCA_REG;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALUOP_BEQ;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = 1'b1;
                o_next               = S_FETCH;
            end
            default: begin
                o_ctrl = '0;
                o_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control unit for the multicycle RISC-V datapath: state register with
// asynchronous reset, plus reset gating of every control output.
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp1,
    output logic       ALUOp0,
    output logic       PCSource,
    output logic       illegal,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_gated;

    multicycle_control_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .i_opcode    (opcode),
        .o_next      (w_next),
        .o_ctrl      (w_ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    // Mealy strobes from the decode would otherwise leak through while reset is held.
    assign w_ctrl_gated = reset ? '0 : w_ctrl;

    assign PCWrite     = w_ctrl_gated.pc_write;
    assign PCWriteCond = w_ctrl_gated.pc_write_cond;
    assign IorD        = w_ctrl_gated.i_or_d;
    assign MemRead     = w_ctrl_gated.mem_read;
    assign MemWrite    = w_ctrl_gated.mem_write;
    assign IRWrite     = w_ctrl_gated.ir_write;
    assign MemtoReg    = w_ctrl_gated.mem_to_reg;
    assign RegWrite    = w_ctrl_gated.reg_write;
    assign ALUSrcA     = w_ctrl_gated.alu_src_a;
    assign ALUSrcB     = w_ctrl_gated.alu_src_b;
    assign ALUOp1      = w_ctrl_gated.alu_op[1];
    assign ALUOp0      = w_ctrl_gated.alu_op[0];
    assign PCSource    = w_ctrl_gated.pc_source;
    assign illegal     = w_ctrl_gated.illegal;
    assign state       = reset ? 4'd0 : r_state;

endmodule
